alu_iterative: RTL and testbench

Multi-cycle execution ALU that consumes the decoded ALU control bundle (opcode, invA, invB, Cin, sign) produced by the ALU-control decoder, together with two operands.
- Add, xor and and-type ops complete in one step.
- Shifts and rotates run serially, one bit position per cycle.
- Valid/ready handshakes on both input and output sides, so the block can sit in the execute stage of the unpipelined datapath or behind a stall-capable pipeline register.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_shift_step.sv | 28 ++
 rtl/alu_iterative.sv | 162 ++++++++++++++++
 tb/tb_alu_iterative.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and default widths for the
// ALU-control decoder and the iterative execution ALU.
package alu_pkg;

   localparam int ALU_N_DEF       = 16;
   localparam int ALU_SHAMT_W_DEF = 4;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_ROR = 3'b001;
   localparam logic [2:0] ALU_XOR = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_SRA = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_ROL = 3'b110;
   localparam logic [2:0] ALU_SLL = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } alu_state_e;

   function automatic logic is_shift_op(input logic [2:0] op);
      return (op != ALU_ADD) && (op != ALU_XOR) && (op != ALU_AND);
   endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-position shift/rotate of an N-bit word, selected by aluOP.
// Non-shift opcodes pass the word through unchanged.
module alu_shift_step
   import alu_pkg::*;
#(
   parameter int N = ALU_N_DEF
) (
   input  logic [2:0]   op,
   input  logic [N-1:0] din,
   output logic [N-1:0] dout
);

   logic signed [N-1:0] din_s;

   always_comb begin
      din_s = din;
      dout  = din;
      case (op)
         ALU_ROR: dout = {din[0], din[N-1:1]};
         ALU_ROL: dout = {din[N-2:0], din[N-1]};
         ALU_SRA: dout = din_s >>> 1;
         ALU_SRL: dout = {1'b0, din[N-1:1]};
         ALU_SLL: dout = {din[N-2:0], 1'b0};
         default: dout = din;
      endcase
   end

endmodule

// File: rtl/alu_iterative.sv
// Multi-cycle ALU: add/xor/and in one step, shifts/rotates one bit per cycle.
// Define ALU_FAST_SHIFT_EN to replace the serial shifter with a barrel shifter.
module alu_iterative
   import alu_pkg::*;
#(
   parameter int N       = ALU_N_DEF,
   parameter int SHAMT_W = ALU_SHAMT_W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [2:0]   aluOP,
   input  logic         invA,
   input  logic         invB,
   input  logic         Cin,
   input  logic         sign,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] Out,
   output logic         Ofl,
   output logic         Zero
);

   function automatic logic add_ofl_f(input logic signed [N-1:0] a,
                                      input logic signed [N-1:0] b,
                                      input logic [N:0]          s,
                                      input logic                sgn);
      if (sgn)
         return (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
      return s[N];
   endfunction

   alu_state_e          state, state_nxt;
   logic                accept;
   logic                go_shift;
   logic                shift_last;
   logic [SHAMT_W-1:0]  amt;
   logic signed [N-1:0] a_m, b_m;
   logic [N:0]          sum;
   logic [N-1:0]        shift_imm;
   logic [N-1:0]        imm_res;
   logic                imm_ofl;
   logic [N-1:0]        res_p1;
   logic                ofl_p1;
   logic                zero_p1;

   assign accept = in_valid && (state == ST_IDLE);
   assign amt    = B[SHAMT_W-1:0];
   assign a_m    = invA ? ~A : A;
   assign b_m    = invB ? ~B : B;
   assign sum    = {1'b0, a_m} + {1'b0, b_m} + {{N{1'b0}}, Cin};

`ifdef ALU_FAST_SHIFT_EN
   // Barrel: stage s applies 2**s single-step shifts when amount bit s is set.
   logic [N-1:0] bar [SHAMT_W+1];

   assign bar[0] = A;
   for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
      logic [N-1:0] chain [(1<<s)+1];
      assign chain[0] = bar[s];
      for (genvar j = 0; j < (1 << s); j++) begin : g_step
         alu_shift_step #(.N(N)) u_step (
            .op   (aluOP),
            .din  (chain[j]),
            .dout (chain[j+1])
         );
      end
      assign bar[s+1] = amt[s] ? chain[1<<s] : bar[s];
   end

   assign shift_imm  = bar[SHAMT_W];
   assign go_shift   = 1'b0;
   assign shift_last = 1'b0;
`else
   logic [SHAMT_W-1:0] cnt_p1;
   logic [2:0]         op_p1;
   logic [N-1:0]       step_out;

   // The result register doubles as the shift register while in SHIFT.
   alu_shift_step #(.N(N)) u_step (
      .op   (op_p1),
      .din  (res_p1),
      .dout (step_out)
   );

   assign shift_imm  = A;
   assign go_shift   = is_shift_op(aluOP) && (amt != '0);
   assign shift_last = (cnt_p1 == SHAMT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_p1 <= '0;
         op_p1  <= ALU_ADD;
      end else if (accept) begin
         cnt_p1 <= amt;
         op_p1  <= aluOP;
      end else if (state == ST_SHIFT) begin
         cnt_p1 <= cnt_p1 - 1'b1;
      end
   end
`endif

   always_comb begin
      imm_res = shift_imm;
      case (aluOP)
         ALU_ADD: imm_res = sum[N-1:0];
         ALU_XOR: imm_res = a_m ^ b_m;
         ALU_AND: imm_res = a_m & b_m;
         default: imm_res = shift_imm;
      endcase
   end

   assign imm_ofl = (aluOP == ALU_ADD) && add_ofl_f(a_m, b_m, sum, sign);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (in_valid) state_nxt = go_shift ? ST_SHIFT : ST_DONE;
         ST_SHIFT: if (shift_last) state_nxt = ST_DONE;
         ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == ST_IDLE);
      out_valid = (state == ST_DONE);
      Out       = res_p1;
      Ofl       = ofl_p1;
      Zero      = zero_p1;
   end

   // Result stage: captured at accept, then stepped while shifting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_p1  <= '0;
         ofl_p1  <= 1'b0;
         zero_p1 <= 1'b0;
      end else if (accept) begin
         res_p1  <= imm_res;
         ofl_p1  <= imm_ofl;
         zero_p1 <= (imm_res == '0);
      end
`ifndef ALU_FAST_SHIFT_EN
      else if (state == ST_SHIFT) begin
         res_p1  <= step_out;
         zero_p1 <= (step_out == '0);
      end
`endif
   end

endmodule

// File: tb/tb_alu_iterative.sv
// Self-checking bench for alu_iterative: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
`timescale 1ns/1ps
module tb_alu_iterative;
   import alu_pkg::*;

`ifdef ALU_FAST_SHIFT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] A = '0;
   logic [15:0] B = '0;
   logic [2:0]  aluOP = ALU_ADD;
   logic        invA = 1'b0, invB = 1'b0, Cin = 1'b0, sign = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] Out;
   logic        Ofl;
   logic        Zero;

   always #5 clk = ~clk;

   alu_iterative #(.N(16), .SHAMT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .aluOP     (aluOP),
      .invA      (invA),
      .invB      (invB),
      .Cin       (Cin),
      .sign      (sign),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Out       (Out),
      .Ofl       (Ofl),
      .Zero      (Zero)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] out;
      logic        ofl;
      int          due;
   } exp_t;

   // Expected result from plain integer arithmetic; due = edges after accept.
   function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  input logic ia, input logic ib, input logic ci, input logic sg);
      exp_t        e;
      logic [15:0] a2, b2;
      int unsigned ur, k;
      int          sr;
      logic [31:0] w;
      a2 = ia ? ~a : a;
      b2 = ib ? ~b : b;
      k  = b % 16;
      w  = {16'h0000, a};
      e.ofl = 1'b0;
      e.due = 0;
      case (op)
         ALU_ADD: begin
            ur    = 32'(a2) + 32'(b2) + 32'(ci);
            e.out = ur[15:0];
            sr    = int'($signed(a2)) + int'($signed(b2)) + int'(ci);
            e.ofl = sg ? ((sr > 32767) || (sr < -32768)) : (ur > 65535);
         end
         ALU_XOR: e.out = a2 ^ b2;
         ALU_AND: e.out = a2 & b2;
         default: begin
            case (op)
               ALU_SRL: w = w >> k;
               ALU_SLL: w = w << k;
               ALU_SRA: w = 32'($signed(a) >>> k);
               ALU_ROL: w = (w << k) | (w >> (16 - k));
               default: w = (w >> k) | (w << (16 - k));
            endcase
            e.out = w[15:0];
            e.due = FAST ? 0 : int'(k);
         end
      endcase
      return e;
   endfunction

   // Scoreboard: capture at negedge, apply at posedge, compare at next negedge.
   exp_t q[$];
   int   cyc = 0;

   initial begin
      exp_t pend;
      bit   take, popn;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q.delete();
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 1);
            check("rst_out", Out, 0);
            check("rst_ofl", Ofl, 0);
            check("rst_zero", Zero, 0);
         end else if (q.size() == 0) begin
            check("idle_in_ready", in_ready, 1);
            check("idle_out_valid", out_valid, 0);
         end else begin
            check("busy_in_ready", in_ready, 0);
            check("out_valid_timing", out_valid, 32'(cyc >= q[0].due));
            if (out_valid) begin
               check("model_out", Out, q[0].out);
               check("model_ofl", Ofl, q[0].ofl);
               check("model_zero", Zero, 32'(q[0].out == 16'h0000));
            end
         end
         take = rst_n && in_valid && in_ready;
         popn = rst_n && out_valid && out_ready;
         pend = model(aluOP, A, B, invA, invB, Cin, sign);
         @(posedge clk);
         cyc++;
         if (rst_n && popn && q.size() > 0) void'(q.pop_front());
         if (rst_n && take) begin
            pend.due += cyc;
            q.push_back(pend);
         end
      end
   end

   function automatic int sw(input int k);
      return FAST ? 0 : k;
   endfunction

   task automatic issue(input string nm, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic ia, input logic ib, input logic ci, input logic sg,
                        input logic [15:0] xo, input logic xf, input int xw, input int hold);
      int n;
      @(posedge clk); #1;
      aluOP = op; A = a; B = b; invA = ia; invB = ib; Cin = ci; sign = sg;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      A = 16'($urandom); B = 16'($urandom); aluOP = 3'($urandom);
      invA = 1'($urandom); invB = 1'($urandom); Cin = 1'($urandom); sign = 1'($urandom);
      n = 0;
      while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
      check({nm, "_wait"}, n, xw);
      check({nm, "_out"}, Out, xo);
      check({nm, "_ofl"}, Ofl, xf);
      check({nm, "_zero"}, Zero, 32'(xo == 16'h0000));
      for (int i = 0; i < hold; i++) begin
         in_valid = ~in_valid;
         A = 16'($urandom); B = 16'($urandom); aluOP = 3'($urandom);
         @(posedge clk); #1;
         check({nm, "_hold_out"}, Out, xo);
         check({nm, "_hold_ofl"}, Ofl, xf);
         check({nm, "_hold_in_ready"}, in_ready, 0);
         check({nm, "_hold_out_valid"}, out_valid, 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({nm, "_ready_back"}, in_ready, 1);
      check({nm, "_valid_drop"}, out_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      issue("add",       ALU_ADD, 16'h0003, 16'h0004, 0, 0, 0, 0, 16'h0007, 0, 0, 0);
      issue("xor_zero",  ALU_XOR, 16'h00FF, 16'h00FF, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
      issue("sub_s",     ALU_ADD, 16'h0001, 16'h8000, 1, 0, 1, 1, 16'h7FFF, 1, 0, 0);
      issue("sub_u",     ALU_ADD, 16'h0001, 16'h8000, 1, 0, 1, 0, 16'h7FFF, 1, 0, 0);
      issue("andn",      ALU_AND, 16'hFF0F, 16'h0F0F, 0, 1, 1, 0, 16'hF000, 0, 0, 0);
      issue("add_sovf",  ALU_ADD, 16'h7FFF, 16'h0001, 0, 0, 0, 1, 16'h8000, 1, 0, 0);
      issue("add_nocy",  ALU_ADD, 16'h7FFF, 16'h0001, 0, 0, 0, 0, 16'h8000, 0, 0, 0);
      issue("add_wrap",  ALU_ADD, 16'hFFFF, 16'h0001, 0, 0, 0, 0, 16'h0000, 1, 0, 0);
      issue("sra",       ALU_SRA, 16'h8010, 16'h0004, 0, 0, 0, 0, 16'hF801, 0, sw(4), 0);
      issue("rol",       ALU_ROL, 16'h8001, 16'h0001, 0, 0, 0, 0, 16'h0003, 0, sw(1), 0);
      issue("sll_k0",    ALU_SLL, 16'h1234, 16'h0000, 0, 0, 0, 0, 16'h1234, 0, 0, 0);
      issue("ror_hiB",   ALU_ROR, 16'h0001, 16'h0013, 0, 0, 0, 0, 16'h2000, 0, sw(3), 0);
      issue("srl_15",    ALU_SRL, 16'h8000, 16'h000F, 0, 0, 0, 0, 16'h0001, 0, sw(15), 0);
      issue("sll_15",    ALU_SLL, 16'h0001, 16'h000F, 0, 0, 0, 0, 16'h8000, 0, sw(15), 0);
      issue("srl_inv",   ALU_SRL, 16'h00F0, 16'h0004, 1, 1, 1, 1, 16'h000F, 0, sw(4), 0);
      issue("sll_out0",  ALU_SLL, 16'h8000, 16'h0001, 0, 0, 0, 0, 16'h0000, 0, sw(1), 0);
      issue("bp_add",    ALU_ADD, 16'h1111, 16'h2222, 0, 0, 0, 0, 16'h3333, 0, 0, 3);
      issue("bp_sra",    ALU_SRA, 16'h4000, 16'h0002, 0, 0, 0, 0, 16'h1000, 0, sw(2), 3);

      // Reset in the middle of a long serial shift.
      @(posedge clk); #1;
      aluOP = ALU_SRL; A = 16'hABCD; B = 16'd10; invA = 0; invB = 0; Cin = 0; sign = 0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_busy", in_ready, 0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out", Out, 0);
      check("mid_rst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      issue("add_after_rst", ALU_ADD, 16'h0001, 16'h0001, 0, 0, 0, 0, 16'h0002, 0, 0, 0);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
